// File: rtl/ram_arb_pkg.sv
// Shared state encoding and parameter defaults for the two-master RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DefAw       = 5;
  localparam int unsigned DefDw       = 8;
  localparam int unsigned DefMaxBurst = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: a lone requester wins, a tie goes to the master that was not last.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       any_o
);

  always_comb begin
    any_o    = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: round-robin grant with a bounded lock burst,
// combinational RAM drive from the owner, registered read return.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW        = DefAw,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic          m0_lock_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_din_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,

  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic          m1_lock_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_din_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,

  output logic          ram_wen_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  localparam int unsigned     CntW      = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            m0_rvalid_q, m0_rvalid_d;
  logic            m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DW-1:0]   m1_rdata_q, m1_rdata_d;

  logic            own_sel;
  logic            own_req;
  logic            own_we;
  logic            own_lock;
  logic            pick_last;
  logic            pick_winner;
  logic            pick_any;
  logic            ram_wen;

  // While owned, last is fed as the owner so a waiting master wins and a lone owner keeps it.
  rr_pick2 u_pick (
    .req_i    ({m1_req_i, m0_req_i}),
    .last_i   (pick_last),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  always_comb begin
    own_sel   = (state_q == StOwn1);
    own_req   = own_sel ? m1_req_i  : m0_req_i;
    own_we    = own_sel ? m1_we_i   : m0_we_i;
    own_lock  = own_sel ? m1_lock_i : m0_lock_i;
    pick_last = (state_q == StIdle) ? last_q : own_sel;

    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    ram_wen     = 1'b0;
    ram_addr_o  = '0;
    ram_din_o   = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d     = pick_winner ? StOwn1 : StOwn0;
          burst_cnt_d = '0;
        end
      end
      StOwn0, StOwn1: begin
        ram_addr_o = own_sel ? m1_addr_i : m0_addr_i;
        ram_din_o  = own_sel ? m1_din_i  : m0_din_i;
        ram_wen    = own_req & own_we;
        if (own_req && own_lock && (burst_cnt_q < BurstLast)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (pick_any) begin
          state_d     = pick_winner ? StOwn1 : StOwn0;
          burst_cnt_d = '0;
          if (pick_winner != own_sel) begin
            last_d = own_sel;
          end
        end else begin
          state_d = StIdle;
          last_d  = own_sel;
        end
      end
      default: state_d = StIdle;
    endcase

    ram_wen_o = ram_wen & ~rst_i;

    m0_rvalid_d = (state_q == StOwn0) & m0_req_i & ~m0_we_i;
    m1_rvalid_d = (state_q == StOwn1) & m1_req_i & ~m1_we_i;
    m0_rdata_d  = m0_rvalid_d ? ram_dout_i : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? ram_dout_i : m1_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt_o    = (state_q == StOwn0);
  assign m1_gnt_o    = (state_q == StOwn1);
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run scored against
// a behavioural arbiter/memory model. Includes a 32x8 RAM with a preload port.
module tb_ram_arbiter;

  localparam int MaxBurst = 4;

  logic       clk;
  logic       rst;
  logic       m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [4:0] m0_addr, m1_addr, ram_addr;
  logic [7:0] m0_din, m1_din, ram_din, ram_dout;
  logic       m0_gnt, m0_rv, m1_gnt, m1_rv, ram_wen;
  logic [7:0] m0_rdata, m1_rdata;

  logic [7:0] ram [32];
  logic       pl_en;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: owner 0=none, 1=m0, 2=m1.
  int         md_own, md_last, md_cnt;
  logic       md_rv [2];
  logic [7:0] md_rd [2];
  logic [7:0] mem_ref [32];
  logic       rq [2], wq [2], lk [2];
  logic [4:0] ad [2];
  logic [7:0] dt [2];

  ram_arbiter #(.AW(5), .DW(8), .MAX_BURST(MaxBurst)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_lock_i   (m0_lock),
    .m0_addr_i   (m0_addr),
    .m0_din_i    (m0_din),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rv),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_lock_i   (m1_lock),
    .m1_addr_i   (m1_addr),
    .m1_din_i    (m1_din),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rv),
    .m1_rdata_o  (m1_rdata),
    .ram_wen_o   (ram_wen),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_wen) ram[ram_addr] <= ram_din;
  end
  assign ram_dout = ram[ram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_din = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_din = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  // Caller holds rst high so the arbiter stays quiet.
  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 0;
  endtask

  function automatic logic [7:0] pre_val(input int a);
    case (a)
      0:       return 8'd3;
      1:       return 8'd2;
      2:       return 8'd4;
      default: return 8'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    m0_req = 1; m0_we = 1;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt, m0_rv, m1_rv, ram_wen} !== 5'b0)
      $display("FAIL reset_ctrl gnt0/gnt1/rv0/rv1/wen got %b want 00000",
               {m0_gnt, m1_gnt, m0_rv, m1_rv, ram_wen});
    else n_pass++;
    n_chk++;
    if ({m0_rdata, m1_rdata} !== 16'h0)
      $display("FAIL reset_rdata got %h want 0000", {m0_rdata, m1_rdata});
    else n_pass++;
    tick();
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 5'd5; m0_din = 8'hA5;
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, ram_wen} !== 2'b00)
      $display("FAIL wr_req_cycle gnt0/wen got %b want 00", {m0_gnt, ram_wen});
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, ram_wen, ram_addr, ram_din} !== {1'b1, 1'b1, 5'd5, 8'hA5})
      $display("FAIL wr_grant gnt0/wen/addr/din got %b want %b",
               {m0_gnt, ram_wen, ram_addr, ram_din}, {1'b1, 1'b1, 5'd5, 8'hA5});
    else n_pass++;
    tick();
    m0_we = 0;
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, ram_wen, ram_addr, m0_rv} !== {1'b1, 1'b0, 5'd5, 1'b0})
      $display("FAIL rd_grant gnt0/wen/addr/rv0 got %b want %b",
               {m0_gnt, ram_wen, ram_addr, m0_rv}, {1'b1, 1'b0, 5'd5, 1'b0});
    else n_pass++;
    tick();
    m0_req = 0;
    @(negedge clk);
    n_chk++;
    if ({m0_rv, m0_rdata, ram_wen} !== {1'b1, 8'hA5, 1'b0})
      $display("FAIL rd_return rv0/rdata0/wen got %b_%h_%b want 1_a5_0",
               m0_rv, m0_rdata, ram_wen);
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m0_rv, m0_rdata} !== {1'b0, 1'b0, 8'hA5})
      $display("FAIL rd_after gnt0/rv0/rdata0 got %b_%b_%h want 0_0_a5", m0_gnt, m0_rv, m0_rdata);
    else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    m0_req = 1; m0_addr = 5'd1; m1_req = 1; m1_addr = 5'd2;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("FAIL tie_after_reset gnt0/gnt1 got %b want 10", {m0_gnt, m1_gnt});
    else n_pass++;
    tick();
    m0_req = 0;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("FAIL handover_no_gap gnt0/gnt1 got %b want 01", {m0_gnt, m1_gnt});
    else n_pass++;
    // Second tie after m0 was last owner: m1 should win.
    do_reset();
    m0_req = 1;
    tick();
    tick();
    m0_req = 0;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt} !== 2'b00)
      $display("FAIL release_idle gnt0/gnt1 got %b want 00", {m0_gnt, m1_gnt});
    else n_pass++;
    m0_req = 1; m1_req = 1;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("FAIL tie_last0 gnt0/gnt1 got %b want 01", {m0_gnt, m1_gnt});
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    logic [4:0] exp_a;
    logic [7:0] exp_d;
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 5'd20; m1_din = 8'h77;
    m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 5'd0; m0_din = 8'h10;
    tick();
    for (int i = 0; i < MaxBurst; i++) begin
      exp_a = 5'(i);
      exp_d = 8'(8'h10 + i);
      m0_addr = exp_a; m0_din = exp_d;
      @(negedge clk);
      n_chk++;
      if ({m0_gnt, m1_gnt, ram_wen, ram_addr, ram_din} !== {1'b1, 1'b0, 1'b1, exp_a, exp_d})
        $display("FAIL lock_beat%0d gnt0/gnt1/wen/addr/din got %b want %b", i,
                 {m0_gnt, m1_gnt, ram_wen, ram_addr, ram_din}, {1'b1, 1'b0, 1'b1, exp_a, exp_d});
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt, ram_addr, ram_din} !== {1'b0, 1'b1, 5'd20, 8'h77})
      $display("FAIL lock_ceiling gnt0/gnt1/addr/din got %b want %b",
               {m0_gnt, m1_gnt, ram_addr, ram_din}, {1'b0, 1'b1, 5'd20, 8'h77});
    else n_pass++;
    tick();
    idle_inputs();
    @(negedge clk);
    for (int i = 0; i < MaxBurst; i++) begin
      exp_d = 8'(8'h10 + i);
      n_chk++;
      if (ram[i] !== exp_d) $display("FAIL lock_mem%0d got %h want %h", i, ram[i], exp_d);
      else n_pass++;
    end
    n_chk++;
    if (ram[20] !== 8'h77) $display("FAIL lock_mem20 got %h want 77", ram[20]);
    else n_pass++;
  endtask

  task automatic test_stream();
    rst = 1;
    idle_inputs();
    for (int a = 0; a < 32; a++) preload(5'(a), pre_val(a));
    rst = 0;
    m1_req = 1; m1_addr = 5'd0;
    tick();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) m1_addr = 5'(i);
      else m1_req = 0;
      @(negedge clk);
      if (i < 10) begin
        n_chk++;
        if ({m1_gnt, m0_gnt} !== 2'b10)
          $display("FAIL stream_gnt%0d gnt1/gnt0 got %b want 10", i, {m1_gnt, m0_gnt});
        else n_pass++;
      end
      n_chk++;
      if (m1_rv !== (i > 0))
        $display("FAIL stream_rv%0d got %b want %b", i, m1_rv, (i > 0));
      else n_pass++;
      if (i > 0) begin
        n_chk++;
        if (m1_rdata !== pre_val(i - 1))
          $display("FAIL stream_rdata%0d got %h want %h", i - 1, m1_rdata, pre_val(i - 1));
        else n_pass++;
      end
      tick();
    end
    @(negedge clk);
    n_chk++;
    if ({m1_gnt, m1_rv} !== 2'b00)
      $display("FAIL stream_end gnt1/rv1 got %b want 00", {m1_gnt, m1_rv});
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    rst = 1;
    idle_inputs();
    preload(5'd8, 8'h00);
    preload(5'd9, 8'h5A);
    rst = 0;
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 5'd8; m1_din = 8'h11;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m1_gnt, ram_wen} !== 2'b11)
      $display("FAIL mid_first gnt1/wen got %b want 11", {m1_gnt, ram_wen});
    else n_pass++;
    tick();
    m1_addr = 5'd9; m1_din = 8'h22; rst = 1;
    @(negedge clk);
    n_chk++;
    if (ram_wen !== 1'b0) $display("FAIL mid_rst_wen got %b want 0", ram_wen);
    else n_pass++;
    tick();
    rst = 0;
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt, m0_rv, m1_rv, ram_wen} !== 5'b0)
      $display("FAIL mid_after gnt0/gnt1/rv0/rv1/wen got %b want 00000",
               {m0_gnt, m1_gnt, m0_rv, m1_rv, ram_wen});
    else n_pass++;
    n_chk++;
    if ({ram[8], ram[9]} !== {8'h11, 8'h5A})
      $display("FAIL mid_mem ram8/ram9 got %h want 115a", {ram[8], ram[9]});
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if (m1_gnt !== 1'b1) $display("FAIL mid_regrant gnt1 got %b want 1", m1_gnt);
    else n_pass++;
    // Reset landing on a read transfer must not leave a pending read pulse.
    m1_we = 0; m1_lock = 0; m1_addr = 5'd8; rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if ({m1_rv, m1_rdata} !== {1'b0, 8'h00})
      $display("FAIL mid_rd_cleared rv1/rdata1 got %b_%h want 0_00", m1_rv, m1_rdata);
    else n_pass++;
  endtask

  task automatic test_drop_req();
    rst = 1;
    idle_inputs();
    preload(5'd3, 8'h00);
    rst = 0;
    m0_req = 1; m0_we = 1; m0_addr = 5'd3; m0_din = 8'hEE;
    tick();
    m0_req = 0;
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, ram_wen} !== 2'b10)
      $display("FAIL drop_gnt gnt0/wen got %b want 10", {m0_gnt, ram_wen});
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if ({m0_gnt, m1_gnt, m0_rv, ram[3]} !== {3'b000, 8'h00})
      $display("FAIL drop_idle gnt0/gnt1/rv0/ram3 got %b want %b",
               {m0_gnt, m1_gnt, m0_rv, ram[3]}, {3'b000, 8'h00});
    else n_pass++;
    idle_inputs();
  endtask

  task automatic model_step(input logic r);
    int x, o, w;
    if (r) begin
      md_own = 0; md_last = 1; md_cnt = 0;
      md_rv[0] = 0; md_rv[1] = 0; md_rd[0] = '0; md_rd[1] = '0;
    end else begin
      md_rv[0] = 0; md_rv[1] = 0;
      if (md_own != 0) begin
        x = md_own - 1;
        if (rq[x]) begin
          if (wq[x]) mem_ref[ad[x]] = dt[x];
          else begin md_rv[x] = 1; md_rd[x] = mem_ref[ad[x]]; end
        end
      end
      if (md_own == 0) begin
        if (rq[0] && rq[1]) begin w = 1 - md_last; md_own = w + 1; end
        else if (rq[0]) md_own = 1;
        else if (rq[1]) md_own = 2;
        md_cnt = 0;
      end else begin
        x = md_own - 1;
        o = 1 - x;
        if (rq[x] && lk[x] && md_cnt < MaxBurst - 1) md_cnt++;
        else if (rq[o]) begin md_own = o + 1; md_last = x; md_cnt = 0; end
        else if (rq[x]) md_cnt = 0;
        else begin md_own = 0; md_last = x; end
      end
    end
  endtask

  task automatic test_random();
    int         x;
    logic       e_wen;
    logic [4:0] e_addr;
    logic [7:0] e_din;
    rst = 1;
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      preload(5'(a), 8'h00);
      mem_ref[a] = 8'h00;
    end
    model_step(1'b1);
    rst = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int m = 0; m < 2; m++) begin
        rq[m] = ($urandom_range(0, 9) < 6);
        wq[m] = $urandom_range(0, 1) == 1;
        lk[m] = $urandom_range(0, 1) == 1;
        ad[m] = 5'($urandom_range(0, 31));
        dt[m] = 8'($urandom_range(0, 255));
      end
      m0_req = rq[0]; m0_we = wq[0]; m0_lock = lk[0]; m0_addr = ad[0]; m0_din = dt[0];
      m1_req = rq[1]; m1_we = wq[1]; m1_lock = lk[1]; m1_addr = ad[1]; m1_din = dt[1];
      e_wen = 0; e_addr = '0; e_din = '0;
      if (md_own != 0) begin
        x = md_own - 1;
        e_addr = ad[x];
        e_din = dt[x];
        e_wen = rq[x] & wq[x] & ~rst;
      end
      @(negedge clk);
      n_chk++;
      if ({m0_gnt, m1_gnt} !== {md_own == 1, md_own == 2})
        $display("FAIL rnd_gnt cyc%0d gnt0/gnt1 got %b want %b", cyc, {m0_gnt, m1_gnt},
                 {md_own == 1, md_own == 2});
      else n_pass++;
      n_chk++;
      if ({ram_wen, ram_addr, ram_din} !== {e_wen, e_addr, e_din})
        $display("FAIL rnd_ram cyc%0d wen/addr/din got %b_%h_%h want %b_%h_%h", cyc,
                 ram_wen, ram_addr, ram_din, e_wen, e_addr, e_din);
      else n_pass++;
      n_chk++;
      if ({m0_rv, m0_rdata, m1_rv, m1_rdata} !== {md_rv[0], md_rd[0], md_rv[1], md_rd[1]})
        $display("FAIL rnd_read cyc%0d rv0/rd0/rv1/rd1 got %b_%h_%b_%h want %b_%h_%b_%h", cyc,
                 m0_rv, m0_rdata, m1_rv, m1_rdata, md_rv[0], md_rd[0], md_rv[1], md_rd[1]);
      else n_pass++;
      model_step(rst);
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    pl_en = 0; pl_addr = '0; pl_data = '0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_lock_burst();
    test_stream();
    test_reset_mid_burst();
    test_drop_req();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer for the 32x8 single-port data RAM (combinational read, write on posedge).
- Master 0 is the CPU control unit. Master 1 is the loader/debug port.
- Grants one master at a time with round-robin fairness and an optional locked burst. Drives the RAM port and returns registered read data.

Parameters:
- AW, 5, RAM address width.
- DW, 8, RAM data width.
- MAX_BURST, 4, maximum consecutive grant cycles while lock is held (range 1..16).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- m0_req_i  in  1  master 0 request.
- m0_we_i  in  1  master 0 write enable (1=write, 0=read).
- m0_lock_i  in  1  master 0 burst lock.
- m0_addr_i  in  AW  master 0 address.
- m0_din_i  in  DW  master 0 write data.
- m0_gnt_o  out  1  master 0 grant (registered).
- m0_rvalid_o  out  1  master 0 read data valid (1-cycle pulse).
- m0_rdata_o  out  DW  master 0 read data.
- m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_din_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as master 0.
- ram_wen_o  out  1  RAM write enable.
- ram_addr_o  out  AW  RAM address.
- ram_din_o  out  DW  RAM write data.
- ram_dout_i  in  DW  RAM read data (combinational from ram_addr_o).

Behaviour:
- Clock/reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - state=IDLE, last=1 (master 0 wins first), burst_cnt=0.
  - All gnt_o, rvalid_o, rdata_o = 0.
  - While rst_i=1, ram_wen_o is forced 0 combinationally.
- States: IDLE, OWN0, OWN1. gnt_x = (state==OWNx), registered.
- Transfer: a cycle with gnt_x=1 and mx_req_i=1. Masters hold req/we/addr/din stable until they sample gnt. If gnt_x=1 and req_x=0, no access occurs (ram_wen_o=0).
- RAM drive:
  - In OWNx, ram_addr_o=mx_addr_i, ram_din_o=mx_din_i, ram_wen_o=mx_req_i & mx_we_i.
  - In IDLE, addr/din=0 and wen=0.
- Read return: a read transfer in cycle N registers ram_dout_i into mx_rdata_o and pulses mx_rvalid_o in cycle N+1. rdata holds its value until the next read for that master.
- IDLE:
  - One request: go to that OWN state.
  - Both requesting: go to OWN of the master != last.
  - None: stay.
  - On entering OWNx, burst_cnt=0.
- OWNx, evaluated each cycle:
  - (a) If req_x & lock_x & burst_cnt<MAX_BURST-1: stay, burst_cnt+1.
  - (b) Else if the other master is requesting: go directly to OWN of the other, no idle bubble; last=x; burst_cnt=0.
  - (c) Else if req_x: stay, burst_cnt=0 (no contention).
  - (d) Else: go to IDLE, last=x.
- Latency:
  - Request from IDLE at cycle N: gnt at N+1, write commits at the end of N+1, rvalid at N+2.
  - Back-to-back transfers at 1 per cycle while owned.
- Lock ceiling: lock never starves the other master beyond MAX_BURST cycles. After MAX_BURST locked cycles with contention, ownership switches.
- Simultaneous first requests after reset: master 0 wins.
- Reset mid-burst: the next cycle is IDLE, no write occurs in the reset cycle, and pending rvalid is cleared.
- Width rules: burst_cnt is $clog2(MAX_BURST)+1 bits. No address arithmetic; addresses pass through unchanged.

Decomposition:
- Shared package ram_arb_pkg:
  - state enum (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10).
  - AW/DW defaults.
  - MAX_BURST default.
- Sub-module rr_pick2: combinational 2-way round-robin select.
  - Inputs: req[1:0], last.
  - Outputs: winner, any.
  - Used by both the IDLE and OWNx transition logic.

Test Plan:
- Reset then m0 writes 8'hA5 to addr 5: gnt0 one cycle after req, ram_wen_o=1 with addr 5 in that cycle. m0 then reads addr 5 and gets m0_rvalid_o pulse with rdata=8'hA5 one cycle after the read grant.
- Both request in the same IDLE cycle after reset: m0 granted first. m0 drops req, m1 granted the next cycle with no IDLE gap. Next simultaneous contention grants m1 (last=0).
- m0 holds lock with continuous requests while m1 requests, MAX_BURST=4: exactly 4 consecutive m0 transfers (addrs 0..3), then gnt1 in the 5th cycle.
- Uncontended m1 stream of 10 reads, no lock: gnt1 held for all 10 cycles. rvalid1 pulses 10 times, each returning the preloaded values (addr0=3, addr1=2, addr2=4, rest 0).
- rst_i asserted during a m1 write burst: ram_wen_o=0 in the reset cycle, all gnt/rvalid=0 the next cycle, state IDLE. The RAM location targeted in the reset cycle is unchanged.
- gnt0 asserted while m0 drops req: ram_wen_o=0, no rvalid, FSM returns to IDLE.
